div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Iterative divide sequencer for the execute stage. It serves RV32M DIV/DIVU/REM/REMU.
- Accepts operands from EX and runs a radix-2 restoring divide, one quotient bit per cycle.
- Raises a stall request to the pipeline controller until the result is ready.
- Returns the result to EX for the writeback path. Branch flush annuls an in-flight operation.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start_i  input  1  EX requests a divide; held high by EX until ready_o seen
- annul_i  input  1  flush: abort current operation (branch taken / pipeline flush)
- signed_i  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU
- rem_i  input  1  1 = return remainder, 0 = return quotient
- dividend_i  input  WIDTH  rs1 value
- divisor_i  input  WIDTH  rs2 value
- result_o  output  WIDTH  quotient or remainder, valid while ready_o=1
- ready_o  output  1  result valid
- stallreq_o  output  1  to pipeline controller; combinational = start_i & ~ready_o & ~annul_i

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, result_o=0, ready_o=0, internal regs cleared.
- States:
  - IDLE
  - DIVZERO
  - ON
  - END
- IDLE:
  - On start_i=1 & annul_i=0, the operation starts.
  - If divisor_i==0, go to DIVZERO.
  - Otherwise latch operands and go to ON:
    - |dividend|, |divisor| when signed_i=1, else raw values.
    - Quotient sign = sign(dividend) XOR sign(divisor).
    - Remainder sign = sign(dividend).
    - Latch rem_i.
    - Counter=0.
  - Operands are sampled only at this edge. Later input changes are ignored.
- ON:
  - Each cycle, shift partial remainder left 1 and bring in the next dividend MSB.
  - Subtract divisor as a WIDTH+1-bit unsigned subtraction.
  - If result is non-negative, keep it and set quotient bit=1. Else restore and set quotient bit=0.
  - Counter increments each cycle. After exactly WIDTH cycles in ON, go to END.
  - On entry to END, apply sign fixup: negate quotient if quotient sign=1; negate remainder if remainder sign=1.
- DIVZERO: next cycle go to END.
  - Quotient = all ones.
  - Remainder = original dividend_i, unsigned or signed alike.
- END:
  - ready_o=1 and result_o holds the selected value.
  - Stay in END while start_i=1. Go to IDLE when start_i=0, which clears ready_o and sets result_o=0.
- Latency, counted from the edge sampling start in IDLE:
  - Normal: ready_o high after WIDTH+1 edges (33 for WIDTH=32).
  - Divide by zero: ready_o high after 2 edges.
- Overflow (signed, dividend=0x80000000, divisor=0xFFFFFFFF): falls out naturally. Quotient=0x80000000, remainder=0, no special state.
- annul_i=1 in any state, including mid-ON or in END:
  - Next state IDLE, ready_o=0, result_o=0.
  - stallreq_o drops in the same cycle.
  - annul_i has priority over start_i.
- A new start_i while in ON/DIVZERO is ignored (EX holds a single request).
- Back-to-back divides: EX drops start_i for at least one cycle (END→IDLE) before the next request. The next start is accepted in IDLE.
- rst asserted mid-operation: immediate return to the reset values above.

Decomposition:
- Shared package/define file holds:
  - state encodings DIV_IDLE, DIV_DIVZERO, DIV_ON, DIV_END (2 bits)
  - DivStart/DivStop, DivResultReady/DivResultNotReady
  - ZeroWord (shared with existing defines)
- Single module. The WIDTH+1-bit conditional subtract step stays inline.
- No sub-module is needed; an optional div_step is acceptable but not required.

Test Plan:
- DIVU 100/7, rem_i=0:
  - stallreq_o=1 for 33 cycles.
  - ready_o rises 33 edges after start, result_o=14.
  - Drop start_i → ready_o=0 next cycle.
- REM signed −100 / 7 → result_o=0xFFFFFFFE (−2). DIV signed −100/7 → 0xFFFFFFF2 (−14). DIV 100/−7 → 0xFFFFFFF2.
- Divide by zero:
  - DIVU 0x1234/0 → result_o=0xFFFFFFFF after 2 edges.
  - REMU 0x1234/0 → 0x00001234.
- Signed overflow 0x80000000 / 0xFFFFFFFF:
  - DIV → 0x80000000.
  - REM → 0x00000000, 33-cycle latency.
- Annul mid-operation:
  - Start DIVU 1000/3, assert annul_i for 1 cycle at iteration 10.
  - Response: stallreq_o=0 same cycle, state IDLE, ready_o never rises.
  - Immediate new DIVU 9/3 → 3 after 33 edges.
- Async reset:
  - Assert rst between clock edges during ON.
  - Response: ready_o=0 and result_o=0 immediately, without waiting for clk.
  - Deassert rst, run DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared encodings and constants for the iterative divide sequencer.
// Imported by div_seq; ZeroWord is shared with the rest of the core.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_DIVZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; result held until EX drops start_i.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_i,
    input  logic             rem_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             stallreq_o
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             rem_sel_q, rem_sel_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ready_q, ready_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             unused_diff;

    // Borrow out of the widened subtract marks a negative trial remainder.
    assign shifted     = {rem_q, quo_q[WIDTH-1]};
    assign diff        = {1'b0, shifted} - {2'b00, dvs_q};
    assign ge          = ~diff[WIDTH+1];
    assign step_rem    = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo    = {quo_q[WIDTH-2:0], ge};
    assign unused_diff = diff[WIDTH];

    assign dvd_neg = signed_i & dividend_i[WIDTH-1];
    assign dvs_neg = signed_i & divisor_i[WIDTH-1];
    assign dvd_abs = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_abs = dvs_neg ? -divisor_i : divisor_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        rem_sel_d = rem_sel_q;
        result_d  = result_q;
        ready_d   = ready_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start_i == DivStart) begin
                    cnt_d     = '0;
                    rem_sel_d = rem_i;
                    if (divisor_i == '0) begin
                        state_d = DIV_DIVZERO;
                        quo_d   = dividend_i;
                    end else begin
                        state_d = DIV_ON;
                        quo_d   = dvd_abs;
                        dvs_d   = dvs_abs;
                        rem_d   = '0;
                        q_neg_d = dvd_neg ^ dvs_neg;
                        r_neg_d = dvd_neg;
                    end
                end
            end
            DIV_DIVZERO: begin
                state_d  = DIV_END;
                ready_d  = DivResultReady;
                result_d = rem_sel_q ? quo_q : '1;
            end
            DIV_ON: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DIV_END;
                    ready_d = DivResultReady;
                    if (rem_sel_q)
                        result_d = r_neg_q ? -step_rem : step_rem;
                    else
                        result_d = q_neg_q ? -step_quo : step_quo;
                end
            end
            DIV_END: begin
                if (start_i == DivStop) begin
                    state_d  = DIV_IDLE;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        // Flush wins over everything, including a held start_i.
        if (annul_i) begin
            state_d  = DIV_IDLE;
            cnt_d    = '0;
            ready_d  = DivResultNotReady;
            result_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            rem_sel_q <= rem_sel_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: transaction-level latency model
// compared every cycle, plus directed vectors with literal expectations.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_i = 1'b0;
    logic        rem_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .rem_i      (rem_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension results from plain arithmetic.
    function automatic logic [31:0] model_res(bit s, bit r,
                                              logic [31:0] a,
                                              logic [31:0] b);
        if (b == 32'd0)
            return r ? a : 32'hFFFF_FFFF;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return r ? 32'd0 : 32'h8000_0000;
            if (r)
                return 32'($signed(a) % $signed(b));
            return 32'($signed(a) / $signed(b));
        end
        return r ? (a % b) : (a / b);
    endfunction

    // Transaction model: accepted request becomes ready after a fixed
    // number of edges; annul and reset abandon it.
    bit          m_busy = 1'b0;
    bit          m_ready = 1'b0;
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_res   = '0;
        end else if (annul_i) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_res   = '0;
        end else if (m_ready) begin
            if (!start_i) begin
                m_ready = 1'b0;
                m_res   = '0;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
                m_res   = m_pend;
            end
        end else if (start_i) begin
            m_busy = 1'b1;
            m_left = (divisor_i == 32'd0) ? 1 : 32;
            m_pend = model_res(signed_i, rem_i, dividend_i, divisor_i);
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("cyc_ready", {31'd0, ready_o}, {31'd0, m_ready});
            chk("cyc_result", result_o, m_res);
            chk("cyc_stall", {31'd0, stallreq_o},
                {31'd0, start_i & ~m_ready & ~annul_i});
        end
    end

    task automatic start_op(bit s, bit r, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        signed_i   = s;
        rem_i      = r;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
    endtask

    // Call right after inputs are set on a falling edge.
    task automatic wait_ready(string name, bit s, bit r,
                              logic [31:0] a, logic [31:0] b,
                              logic [31:0] exp, int lat, bit drop);
        int n;
        int st;
        n  = 0;
        st = 0;
        chk({name, "_model"}, model_res(s, r, a, b), exp);
        #1;
        if (stallreq_o) st++;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o) break;
            if (stallreq_o) st++;
        end
        if (!ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: ready_o low after %0d edges", name, n);
        end
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_stall"}, 32'(st), 32'(lat));
        chk({name, "_res"}, result_o, exp);
        if (drop) begin
            @(negedge clk);
            start_i = 1'b0;
            @(posedge clk);
            #1;
            chk({name, "_drop"}, {31'd0, ready_o}, 32'd0);
        end
    endtask

    initial begin
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        start_op(0, 0, 32'd100, 32'd7);
        wait_ready("divu_100_7", 0, 0, 32'd100, 32'd7, 32'd14, 33, 1);
        start_op(0, 1, 32'd100, 32'd7);
        wait_ready("remu_100_7", 0, 1, 32'd100, 32'd7, 32'd2, 33, 1);
        start_op(1, 1, 32'hFFFF_FF9C, 32'd7);
        wait_ready("rem_m100_7", 1, 1, 32'hFFFF_FF9C, 32'd7,
                   32'hFFFF_FFFE, 33, 1);
        start_op(1, 0, 32'hFFFF_FF9C, 32'd7);
        wait_ready("div_m100_7", 1, 0, 32'hFFFF_FF9C, 32'd7,
                   32'hFFFF_FFF2, 33, 1);
        start_op(1, 0, 32'd100, 32'hFFFF_FFF9);
        wait_ready("div_100_m7", 1, 0, 32'd100, 32'hFFFF_FFF9,
                   32'hFFFF_FFF2, 33, 1);
        start_op(0, 0, 32'h1234, 32'd0);
        wait_ready("divu_z", 0, 0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2, 1);
        start_op(0, 1, 32'h1234, 32'd0);
        wait_ready("remu_z", 0, 1, 32'h1234, 32'd0, 32'h0000_1234, 2, 1);
        start_op(1, 1, 32'hFFFF_FFF9, 32'd0);
        wait_ready("rem_z_neg", 1, 1, 32'hFFFF_FFF9, 32'd0,
                   32'hFFFF_FFF9, 2, 1);
        start_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready("div_ovf", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h8000_0000, 33, 1);
        start_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready("rem_ovf", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h0000_0000, 33, 1);

        // Flush mid-iteration, then an immediate new request.
        start_op(0, 0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        dividend_i = 32'd7;
        annul_i    = 1'b1;
        #1;
        chk("annul_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("annul_ready", {31'd0, ready_o}, 32'd0);
        chk("annul_result", result_o, 32'd0);
        @(negedge clk);
        annul_i    = 1'b0;
        dividend_i = 32'd9;
        divisor_i  = 32'd3;
        wait_ready("after_annul", 0, 0, 32'd9, 32'd3, 32'd3, 33, 1);

        // Async reset while iterating.
        start_op(0, 0, 32'd5000, 32'd9);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_on_ready", {31'd0, ready_o}, 32'd0);
        chk("arst_on_result", result_o, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
        start_op(0, 0, 32'hFFFF_FFFF, 32'd1);
        wait_ready("divu_max_1", 0, 0, 32'hFFFF_FFFF, 32'd1,
                   32'hFFFF_FFFF, 33, 0);

        // Async reset while a result is being held.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_end_ready", {31'd0, ready_o}, 32'd0);
        chk("arst_end_result", result_o, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
        start_op(0, 1, 32'd12345, 32'd100);
        wait_ready("remu_after_rst", 0, 1, 32'd12345, 32'd100,
                   32'd45, 33, 1);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
